// File: rtl/unidade_controle.sv
// unidade_controle: multicycle control FSM (fetch/decode/exec/mem/wb) with memory timeout and sticky fault
// Ports: clock, reset (sync, active-high); opcode, zero, mem_ready in;
//   mem_req, mem_we, ir_write, pc_write, pc_src, im_sel, alu_op, reg_write, fault, state, retired out.
// Define UNIDADE_CONTROLE_RETIRED_EN to build the retired-instruction counter; otherwise retired reads 0.
module unidade_controle #(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [5:0]  opcode,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        ir_write,
  output logic        pc_write,
  output logic [1:0]  pc_src,
  output logic [1:0]  im_sel,
  output logic [2:0]  alu_op,
  output logic        reg_write,
  output logic        fault,
  output logic [2:0]  state,
  output logic [31:0] retired
);
  localparam logic [2:0] S_FETCH = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC = 3'd2;
  localparam logic [2:0] S_MEM = 3'd3;
  localparam logic [2:0] S_WB = 3'd4;
  localparam logic [2:0] S_FAULT = 3'd7;
  localparam logic [5:0] OP_R = 6'h00;
  localparam logic [5:0] OP_J = 6'h02;
  localparam logic [5:0] OP_BEQ = 6'h04;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_LI = 6'h0F;
  localparam logic [5:0] OP_LW = 6'h23;
  localparam logic [5:0] OP_SW = 6'h2B;
  localparam int WW = $clog2(TIMEOUT_CYC + 1);
  logic [2:0] r_state, w_next;
  logic [5:0] r_op;
  logic [1:0] r_im;
  logic [WW-1:0] r_wait;
  logic w_fetch, w_exec, w_mem, w_wb;
  logic w_r, w_j, w_beq, w_addi, w_li, w_lw, w_sw, w_legal, w_tmo;
  logic [1:0] w_im;
  assign w_fetch = r_state == S_FETCH;
  assign w_exec = r_state == S_EXEC;
  assign w_mem = r_state == S_MEM;
  assign w_wb = r_state == S_WB;
  assign w_r = r_op == OP_R;
  assign w_j = r_op == OP_J;
  assign w_beq = r_op == OP_BEQ;
  assign w_addi = r_op == OP_ADDI;
  assign w_li = r_op == OP_LI;
  assign w_lw = r_op == OP_LW;
  assign w_sw = r_op == OP_SW;
  assign w_legal = w_r | w_j | w_beq | w_addi | w_li | w_lw | w_sw;
  assign w_im = w_j ? 2'b00 : (w_addi | w_li) ? 2'b01 : w_r ? 2'b11 : 2'b10;
  // Last waiting cycle without a strobe; a strobe in that same cycle still completes.
  assign w_tmo = (r_wait == WW'(TIMEOUT_CYC - 1)) && !mem_ready;
  always_comb begin
    w_next = S_FAULT;
    case (r_state)
      S_FETCH:  w_next = mem_ready ? S_DECODE : w_tmo ? S_FAULT : S_FETCH;
      S_DECODE: w_next = w_legal ? S_EXEC : S_FAULT;
      S_EXEC:   w_next = (w_lw | w_sw) ? S_MEM : (w_j | w_beq) ? S_FETCH : S_WB;
      S_MEM:    w_next = mem_ready ? (w_sw ? S_FETCH : S_WB) : w_tmo ? S_FAULT : S_MEM;
      S_WB:     w_next = S_FETCH;
      default:  w_next = S_FAULT;
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_FETCH;
      r_op <= '0;
      r_im <= 2'b11;
      r_wait <= '0;
    end else begin
      r_state <= w_next;
      r_wait <= (w_next != r_state) ? '0 : r_wait + 1'b1;
      if (ir_write) r_op <= opcode;
      if (r_state == S_DECODE && w_legal) r_im <= w_im;
    end
  end
  assign mem_req = w_fetch | w_mem;
  assign mem_we = w_mem & w_sw;
  assign ir_write = w_fetch & mem_ready;
  assign pc_write = ir_write | (w_exec & (w_j | (w_beq & zero)));
  assign pc_src = (w_exec & w_j) ? 2'b10 : (w_exec & w_beq) ? 2'b01 : 2'b00;
  assign alu_op = !w_exec ? 3'b000 : w_r ? 3'b010 : w_li ? 3'b011 : w_beq ? 3'b001 : 3'b000;
  assign reg_write = w_wb;
  assign fault = r_state == S_FAULT;
  assign state = r_state;
  assign im_sel = r_im;
`ifdef UNIDADE_CONTROLE_RETIRED_EN
  logic [31:0] r_ret;
  logic w_retire;
  assign w_retire = (w_exec & (w_j | w_beq)) | (w_mem & mem_ready & w_sw) | w_wb;
  always_ff @(posedge clock) begin
    if (reset) r_ret <= '0;
    else if (w_retire) r_ret <= r_ret + 32'd1;
  end
  assign retired = r_ret;
`else
  assign retired = 32'h0;
`endif
endmodule
